// File: rtl/p2p_pkg.sv
// Shared constants for the point-to-point link: delivery counter width and default geometry.
package p2p_pkg;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_DEPTH = 4;

endpackage

// File: rtl/p2p_fifo.sv
// One direction of the link: DEPTH x WIDTH first-in first-out buffer with valid/ready on both
// sides, an occupancy level and a modulo-2^CNT_W delivery counter.
module p2p_fifo
   import p2p_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [CNT_W-1:0]             count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_c;
   logic             pop_c;
   logic [LVL_W-1:0] level_nxt_c;

   // in_ready is already low when full, so a same-edge pop never frees room for a push
   assign push_c = in_valid & in_ready;
   assign pop_c  = out_valid & out_ready;

   always_comb begin
      level_nxt_c = level;
      if (push_c && !pop_c) begin
         level_nxt_c = level + LVL_W'(1);
      end else if (!push_c && pop_c) begin
         level_nxt_c = level - LVL_W'(1);
      end
   end

   // Handshake flags are registered from the next level so they track occupancy exactly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + CNT_W'(1);
         end
         level     <= level_nxt_c;
         in_ready  <= (level_nxt_c < LVL_W'(DEPTH));
         out_valid <= (level_nxt_c != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Gate with out_valid so never-written storage cannot leak onto the output
   assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/p2p_link.sv
// Bidirectional point-to-point link: two independent p2p_fifo instances, A to B and B to A.
module p2p_link
   import p2p_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             a_tx_data,
   input  logic                         a_tx_valid,
   output logic                         a_tx_ready,
   output logic [WIDTH-1:0]             b_rx_data,
   output logic                         b_rx_valid,
   input  logic                         b_rx_ready,
   input  logic [WIDTH-1:0]             b_tx_data,
   input  logic                         b_tx_valid,
   output logic                         b_tx_ready,
   output logic [WIDTH-1:0]             a_rx_data,
   output logic                         a_rx_valid,
   input  logic                         a_rx_ready,
   output logic [$clog2(DEPTH+1)-1:0]   ab_level,
   output logic [$clog2(DEPTH+1)-1:0]   ba_level,
   output logic [CNT_W-1:0]             ab_count,
   output logic [CNT_W-1:0]             ba_count
);

   p2p_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ab (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (a_tx_data),
      .in_valid  (a_tx_valid),
      .in_ready  (a_tx_ready),
      .out_data  (b_rx_data),
      .out_valid (b_rx_valid),
      .out_ready (b_rx_ready),
      .level     (ab_level),
      .count     (ab_count)
   );

   p2p_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ba (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (b_tx_data),
      .in_valid  (b_tx_valid),
      .in_ready  (b_tx_ready),
      .out_data  (a_rx_data),
      .out_valid (a_rx_valid),
      .out_ready (a_rx_ready),
      .level     (ba_level),
      .count     (ba_count)
   );

endmodule

// File: tb/tb_p2p_link.sv
// Self-checking bench for p2p_link: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based reference model.
module tb_p2p_link;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a_tx_data;
   logic             a_tx_valid;
   logic             a_tx_ready;
   logic [WIDTH-1:0] b_rx_data;
   logic             b_rx_valid;
   logic             b_rx_ready;
   logic [WIDTH-1:0] b_tx_data;
   logic             b_tx_valid;
   logic             b_tx_ready;
   logic [WIDTH-1:0] a_rx_data;
   logic             a_rx_valid;
   logic             a_rx_ready;
   logic [LVL_W-1:0] ab_level;
   logic [LVL_W-1:0] ba_level;
   logic [15:0]      ab_count;
   logic [15:0]      ba_count;

   int n_pass  = 0;
   int n_total = 0;

   p2p_link #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_tx_data  (a_tx_data),
      .a_tx_valid (a_tx_valid),
      .a_tx_ready (a_tx_ready),
      .b_rx_data  (b_rx_data),
      .b_rx_valid (b_rx_valid),
      .b_rx_ready (b_rx_ready),
      .b_tx_data  (b_tx_data),
      .b_tx_valid (b_tx_valid),
      .b_tx_ready (b_tx_ready),
      .a_rx_data  (a_rx_data),
      .a_rx_valid (a_rx_valid),
      .a_rx_ready (a_rx_ready),
      .ab_level   (ab_level),
      .ba_level   (ba_level),
      .ab_count   (ab_count),
      .ba_count   (ba_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Advance one rising edge and settle past it before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_tx_data  = '0;
      a_tx_valid = 1'b0;
      b_rx_ready = 1'b0;
      b_tx_data  = '0;
      b_tx_valid = 1'b0;
      a_rx_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [WIDTH-1:0] tx_data;
      logic             tx_valid;
      logic             rx_ready;
      logic [LVL_W-1:0] exp_level;
      logic             exp_tx_ready;
      logic             exp_rx_valid;
      logic [WIDTH-1:0] exp_rx_data;
      logic [15:0]      exp_count;
   } vec_t;

   vec_t vecs [10];

   logic [WIDTH-1:0] rec_b [$];
   logic [WIDTH-1:0] rec_a [$];
   logic [WIDTH-1:0] mq_ab [$];
   logic [WIDTH-1:0] mq_ba [$];
   logic [15:0]      mc_ab;
   logic [15:0]      mc_ba;

   initial begin
      // A to B: fill with 3,9,C,5; hold F while full and draining; drain to empty and beyond
      vecs[0] = '{4'h3, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 4'h3, 16'd0};
      vecs[1] = '{4'h9, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 4'h3, 16'd0};
      vecs[2] = '{4'hC, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 4'h3, 16'd0};
      vecs[3] = '{4'h5, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 4'h3, 16'd0};
      vecs[4] = '{4'hF, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 4'h9, 16'd1};
      vecs[5] = '{4'hF, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 4'hC, 16'd2};
      vecs[6] = '{4'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 4'h5, 16'd3};
      vecs[7] = '{4'h0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 4'hF, 16'd4};
      vecs[8] = '{4'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 4'h0, 16'd5};
      vecs[9] = '{4'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 4'h0, 16'd5};

      do_reset();

      // Idle after reset
      tick();
      check("rst_a_tx_ready", a_tx_ready, 1);
      check("rst_b_tx_ready", b_tx_ready, 1);
      check("rst_a_rx_valid", a_rx_valid, 0);
      check("rst_b_rx_valid", b_rx_valid, 0);
      check("rst_ab_level", ab_level, 0);
      check("rst_ba_level", ba_level, 0);
      check("rst_ab_count", ab_count, 0);
      check("rst_ba_count", ba_count, 0);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         a_tx_data  = vecs[i].tx_data;
         a_tx_valid = vecs[i].tx_valid;
         b_rx_ready = vecs[i].rx_ready;
         tick();
         check($sformatf("vec%0d_level", i), ab_level, vecs[i].exp_level);
         check($sformatf("vec%0d_tx_ready", i), a_tx_ready, vecs[i].exp_tx_ready);
         check($sformatf("vec%0d_rx_valid", i), b_rx_valid, vecs[i].exp_rx_valid);
         if (vecs[i].exp_rx_valid)
            check($sformatf("vec%0d_rx_data", i), b_rx_data, vecs[i].exp_rx_data);
         check($sformatf("vec%0d_count", i), ab_count, vecs[i].exp_count);
         check($sformatf("vec%0d_ba_level", i), ba_level, 0);
      end
      idle_inputs();

      // Reset with three B-to-A messages buffered and handshakes active in the reset cycle
      do_reset();
      for (int i = 0; i < 3; i++) begin
         b_tx_data  = 4'(4'hA + i);
         b_tx_valid = 1'b1;
         tick();
      end
      b_tx_valid = 1'b0;
      a_rx_ready = 1'b1;
      check("pre_rst_ba_level", ba_level, 3);
      b_tx_valid = 1'b1;
      b_tx_data  = 4'h7;
      rst_n      = 1'b0;
      tick();
      check("mid_rst_ba_level", ba_level, 0);
      check("mid_rst_a_rx_valid", a_rx_valid, 0);
      check("mid_rst_ba_count", ba_count, 0);
      check("mid_rst_b_tx_ready", b_tx_ready, 1);
      rst_n      = 1'b1;
      b_tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_no_stale", a_rx_valid, 0);
      end
      check("post_rst_ba_count", ba_count, 0);

      // Both directions streaming concurrently with receivers always ready
      do_reset();
      b_rx_ready = 1'b1;
      a_rx_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         a_tx_valid = (i < 8);
         b_tx_valid = (i < 8);
         a_tx_data  = 4'(i + 1);
         b_tx_data  = 4'(8 - i);
         tick();
         check("dual_ab_level_le1", 32'(ab_level <= 1), 1);
         check("dual_ba_level_le1", 32'(ba_level <= 1), 1);
         if (i == 0) begin
            check("dual_first_b_valid", b_rx_valid, 1);
            check("dual_first_b_data", b_rx_data, 1);
            check("dual_first_a_valid", a_rx_valid, 1);
            check("dual_first_a_data", a_rx_data, 8);
         end
         if (b_rx_valid) rec_b.push_back(b_rx_data);
         if (a_rx_valid) rec_a.push_back(a_rx_data);
      end
      check("dual_b_len", rec_b.size(), 8);
      check("dual_a_len", rec_a.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < rec_b.size()) check($sformatf("dual_b_seq%0d", i), rec_b[i], i + 1);
         if (i < rec_a.size()) check($sformatf("dual_a_seq%0d", i), rec_a[i], 8 - i);
      end
      check("dual_ab_count", ab_count, 8);
      check("dual_ba_count", ba_count, 8);
      idle_inputs();

      // Random traffic against a queue model of each direction
      do_reset();
      mq_ab.delete();
      mq_ba.delete();
      mc_ab = '0;
      mc_ba = '0;
      for (int c = 0; c < 400; c++) begin
         logic push_ab, pop_ab, push_ba, pop_ba;
         b_rx_ready = 1'($urandom_range(0, 1));
         a_rx_ready = 1'($urandom_range(0, 3) != 0);
         push_ab = a_tx_valid && (mq_ab.size() < DEPTH);
         push_ba = b_tx_valid && (mq_ba.size() < DEPTH);
         pop_ab  = b_rx_ready && (mq_ab.size() > 0);
         pop_ba  = a_rx_ready && (mq_ba.size() > 0);
         if (pop_ab) begin void'(mq_ab.pop_front()); mc_ab++; end
         if (pop_ba) begin void'(mq_ba.pop_front()); mc_ba++; end
         if (push_ab) mq_ab.push_back(a_tx_data);
         if (push_ba) mq_ba.push_back(b_tx_data);
         tick();
         check("rnd_ab_level", ab_level, mq_ab.size());
         check("rnd_ba_level", ba_level, mq_ba.size());
         check("rnd_a_tx_ready", a_tx_ready, mq_ab.size() < DEPTH);
         check("rnd_b_tx_ready", b_tx_ready, mq_ba.size() < DEPTH);
         check("rnd_b_rx_valid", b_rx_valid, mq_ab.size() > 0);
         check("rnd_a_rx_valid", a_rx_valid, mq_ba.size() > 0);
         if (mq_ab.size() > 0) check("rnd_b_rx_data", b_rx_data, mq_ab[0]);
         if (mq_ba.size() > 0) check("rnd_a_rx_data", a_rx_data, mq_ba[0]);
         check("rnd_ab_count", ab_count, mc_ab);
         check("rnd_ba_count", ba_count, mc_ba);
         // Senders hold a refused message; otherwise pick a fresh one
         if (!(a_tx_valid && !push_ab)) begin
            a_tx_valid = 1'($urandom_range(0, 2) != 0);
            a_tx_data  = 4'($urandom);
         end
         if (!(b_tx_valid && !push_ba)) begin
            b_tx_valid = 1'($urandom_range(0, 1));
            b_tx_data  = 4'($urandom);
         end
      end
      idle_inputs();

      // Delivery counter wrap: 65535 deliveries, then one more
      do_reset();
      a_tx_valid = 1'b1;
      b_rx_ready = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         a_tx_data = 4'(i);
         tick();
      end
      check("wrap_ab_count_max", ab_count, 16'hFFFF);
      tick();
      check("wrap_ab_count_zero", ab_count, 0);
      check("wrap_ba_count", ba_count, 0);
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/p2p_link.md
P2P_LINK -- requirements
Module: p2p_link

Interface
REQ-001 SHALL have parameter WIDTH, default 4: message width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 4: entries per direction buffer, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports a_tx_data  input  WIDTH, a_tx_valid  input  1, a_tx_ready  output  1: endpoint A send, A to B.
REQ-006 SHALL have ports b_rx_data  output  WIDTH, b_rx_valid  output  1, b_rx_ready  input  1: endpoint B receive, A to B.
REQ-007 SHALL have ports b_tx_data  input  WIDTH, b_tx_valid  input  1, b_tx_ready  output  1: endpoint B send, B to A.
REQ-008 SHALL have ports a_rx_data  output  WIDTH, a_rx_valid  output  1, a_rx_ready  input  1: endpoint A receive, B to A.
REQ-009 SHALL have ports ab_level, ba_level  output  clog2(DEPTH+1)  current occupancy of each direction.
REQ-010 SHALL have ports ab_count, ba_count  output  16  messages delivered per direction, modulo 2^16.

Function
REQ-011 SHALL run two independent directions, A to B and B to A, each a FIFO of DEPTH x WIDTH; no interaction between directions.
REQ-012 SHALL accept a message when tx_valid and tx_ready are both 1 at a rising edge; tx_ready SHALL be 1 iff the direction's level < DEPTH.
REQ-013 SHALL deliver a message when rx_valid and rx_ready are both 1 at a rising edge; rx_valid SHALL be 1 iff level > 0.
REQ-014 rx_data SHALL equal the oldest stored message whenever rx_valid is 1; rx_data is don't-care when rx_valid is 0.
REQ-015 Latency: a message accepted at edge N SHALL be visible on rx_data/rx_valid after edge N; there is no same-cycle combinational bypass.
REQ-016 Order SHALL be strictly first-in first-out per direction; no loss, duplication or reordering.
REQ-017 Simultaneous accept and deliver on one edge SHALL leave level unchanged and move both pointers.
REQ-018 Full: tx_ready is 0, and a deliver in the same cycle SHALL NOT allow a write on that edge; tx_ready returns to 1 after the edge.
REQ-019 Empty: rx_valid is 0, rx_ready is ignored, and level and count SHALL NOT change.
REQ-020 tx_valid asserted while tx_ready is 0 SHALL have no effect; the sender holds data and valid until accepted.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0; level SHALL be derived without ambiguity between full and empty.
REQ-022 ab_count / ba_count SHALL increment by 1 on each deliver and wrap 65535 to 0.
REQ-023 All outputs SHALL be driven to known values at all times after the first reset; no X or Z on outputs.

Reset
REQ-024 With rst_n low at a rising edge, each direction SHALL be cleared: pointers 0, level 0, count 0, rx_valid 0, tx_ready 1 on the following cycle.
REQ-025 A reset mid-transfer SHALL discard all buffered messages; handshakes in the reset cycle SHALL be ignored.
REQ-026 Buffer storage contents need no reset.

Structure
REQ-027 The shared package p2p_pkg SHALL hold the count width constant (16) and the default WIDTH/DEPTH values.
REQ-028 One sub-module, p2p_fifo (parameters WIDTH, DEPTH; valid/ready in and out, level, count), SHALL be instantiated twice, once per direction.

Verification
REQ-029 Reset, then idle -> a_tx_ready=b_tx_ready=1, a_rx_valid=b_rx_valid=0, levels 0, counts 0.
REQ-030 WIDTH=4, DEPTH=4: A sends 4'h3,4'h9,4'hC,4'h5 with b_rx_ready=0 -> ab_level=4, a_tx_ready=0; then b_rx_ready=1 -> B receives 3,9,C,5 in order on 4 consecutive edges, ab_count=4.
REQ-031 Full FIFO, a 5th value 4'hF held valid while B reads on the same edge -> 4'hF not accepted that edge, accepted next edge, delivered 5th.
REQ-032 Both directions at once: A streams 1..8, B streams 8..1, both rx_ready=1 -> each receiver gets its sequence intact, with a 1-cycle first latency, and levels never exceed 1.
REQ-033 Reset asserted with ba_level=3 -> after the edge, ba_level=0, a_rx_valid=0, ba_count=0; the previously stored data never appears.
REQ-034 Preload ab_count to 65535 by 65535 deliveries -> one more deliver gives ab_count=0.
